// File: rtl/fetch_decode_queue_if.sv
// Fetch/decode handshake bundle for fetch_decode_queue; master is the
// fetch+decode side (bench or pipeline), slave is the queue itself.
interface fetch_decode_queue_if #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned WORD_W = 32
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic              flush;
  logic              f_valid;
  logic              f_ready;
  logic [WORD_W-1:0] f_pc;
  logic [WORD_W-1:0] f_inst;
  logic [WORD_W-1:0] f_branch_target;
  logic              f_branch_predict;
  logic              d_valid;
  logic              d_ready;
  logic [WORD_W-1:0] d_pc;
  logic [WORD_W-1:0] d_inst;
  logic [WORD_W-1:0] d_branch_target;
  logic              d_branch_predict;
  logic [CW-1:0]     count;

  modport master (
    output flush, f_valid, f_pc, f_inst, f_branch_target, f_branch_predict, d_ready,
    input  f_ready, d_valid, d_pc, d_inst, d_branch_target, d_branch_predict, count
  );

  modport slave (
    input  flush, f_valid, f_pc, f_inst, f_branch_target, f_branch_predict, d_ready,
    output f_ready, d_valid, d_pc, d_inst, d_branch_target, d_branch_predict, count
  );
endinterface

// File: rtl/fetch_decode_queue.sv
// Circular-buffer fetch-to-decode instruction queue with flush.
// Define FETCH_DECODE_QUEUE_BYPASS_EN for a zero-latency empty-queue bypass.
module fetch_decode_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned WORD_W = 32
) (
  input logic                 CLK,
  input logic                 nRST,
  fetch_decode_queue_if.slave q
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]       head, tail;
  logic              empty, full, enq, deq, bypass;
  logic [WORD_W-1:0] pc_mem  [DEPTH];
  logic [WORD_W-1:0] inst_mem[DEPTH];
  logic [WORD_W-1:0] tgt_mem [DEPTH];
  logic [DEPTH-1:0]  bp_mem;

  assign empty = (head == tail);
  assign full  = (head[AW-1:0] == tail[AW-1:0]) && (head[AW] != tail[AW]);

`ifdef FETCH_DECODE_QUEUE_BYPASS_EN
  // Gated by nRST so outputs hold reset values while reset is asserted.
  assign bypass = empty && q.f_valid && !q.flush && nRST;
`else
  assign bypass = 1'b0;
`endif

  assign q.f_ready = !full;
  assign q.d_valid = !empty || bypass;
  assign q.count   = tail - head;

  // A bypassed instruction consumed in the same cycle is never written.
  assign enq = q.f_valid && !full && !q.flush && !(bypass && q.d_ready);
  assign deq = !empty && q.d_ready && !q.flush;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head <= '0;
      tail <= '0;
    end else if (q.flush) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (enq) tail <= tail + PTR_ONE;
      if (deq) head <= head + PTR_ONE;
    end
  end

  always_ff @(posedge CLK) begin
    if (enq) begin
      pc_mem  [tail[AW-1:0]] <= q.f_pc;
      inst_mem[tail[AW-1:0]] <= q.f_inst;
      tgt_mem [tail[AW-1:0]] <= q.f_branch_target;
      bp_mem  [tail[AW-1:0]] <= q.f_branch_predict;
    end
  end

  always_comb begin
    q.d_pc             = '0;
    q.d_inst           = '0;
    q.d_branch_target  = '0;
    q.d_branch_predict = 1'b0;
    if (bypass) begin
      q.d_pc             = q.f_pc;
      q.d_inst           = q.f_inst;
      q.d_branch_target  = q.f_branch_target;
      q.d_branch_predict = q.f_branch_predict;
    end else if (!empty) begin
      q.d_pc             = pc_mem  [head[AW-1:0]];
      q.d_inst           = inst_mem[head[AW-1:0]];
      q.d_branch_target  = tgt_mem [head[AW-1:0]];
      q.d_branch_predict = bp_mem  [head[AW-1:0]];
    end
  end
endmodule
